// File: rtl/pong_pkg.sv
// Shared definitions for the pong video path: object field widths, the
// object record carried by every slot, frame geometry and colour constants.
package pong_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int SZ_W  = 6;
  localparam int RGB_W = 3;

  // First line of vertical blanking for 640x480.
  localparam int V_ACTIVE = 480;

  localparam logic [RGB_W-1:0] COLOR_BLACK = 3'b000;
  localparam logic [RGB_W-1:0] COLOR_RED   = 3'b100;
  localparam logic [RGB_W-1:0] COLOR_GREEN = 3'b010;
  localparam logic [RGB_W-1:0] COLOR_BLUE  = 3'b001;
  localparam logic [RGB_W-1:0] COLOR_WHITE = 3'b111;

  // One rectangular object: enable, top-left corner, size and colour.
  typedef struct packed {
    logic             en;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [SZ_W-1:0]  w;
    logic [SZ_W-1:0]  h;
    logic [RGB_W-1:0] color;
  } obj_t;

  // Scheduler phases: normal running, and the single frame-commit cycle.
  typedef enum logic {
    RUN    = 1'b0,
    COMMIT = 1'b1
  } sched_state_t;

  // Builds an object record from its individual fields.
  function automatic obj_t make_obj(input logic en, input logic [X_W-1:0] x,
                                    input logic [Y_W-1:0] y, input logic [SZ_W-1:0] w,
                                    input logic [SZ_W-1:0] h, input logic [RGB_W-1:0] color);
    obj_t o;
    o.en    = en;
    o.x     = x;
    o.y     = y;
    o.w     = w;
    o.h     = h;
    o.color = color;
    return o;
  endfunction

endpackage

// File: rtl/object_layer_scheduler_if.sv
// Object update bus from game logic into the layer scheduler.
// The game side is the master; the scheduler returns upd_ready.
interface object_layer_scheduler_if #(
  parameter int ID_W = 2
);
  import pong_pkg::*;

  logic             upd_valid;
  logic             upd_ready;
  logic [ID_W-1:0]  upd_id;
  logic [X_W-1:0]   upd_x;
  logic [Y_W-1:0]   upd_y;
  logic [SZ_W-1:0]  upd_w;
  logic [SZ_W-1:0]  upd_h;
  logic [RGB_W-1:0] upd_color;
  logic             upd_en;

  modport master (
    output upd_valid, upd_id, upd_x, upd_y, upd_w, upd_h, upd_color, upd_en,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_id, upd_x, upd_y, upd_w, upd_h, upd_color, upd_en,
    output upd_ready
  );

endinterface

// File: rtl/obj_hit_test.sv
// Pure comparator: does the current beam position fall inside one object?
// End coordinates are computed one bit wider so objects near the right or
// bottom edge never wrap around to the opposite side of the screen.
module obj_hit_test
  import pong_pkg::*;
(
  input  obj_t           obj,
  input  logic [X_W-1:0] cx,
  input  logic [Y_W-1:0] cy,
  output logic           hit
);

  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;
  logic         in_x;
  logic         in_y;
  logic         has_area;

  assign x_end    = {1'b0, obj.x} + {{(X_W + 1 - SZ_W){1'b0}}, obj.w};
  assign y_end    = {1'b0, obj.y} + {{(Y_W + 1 - SZ_W){1'b0}}, obj.h};
  assign in_x     = (cx >= obj.x) && ({1'b0, cx} < x_end);
  assign in_y     = (cy >= obj.y) && ({1'b0, cy} < y_end);
  assign has_area = (obj.w != '0) && (obj.h != '0);
  assign hit      = obj.en && has_area && in_x && in_y;

endmodule

// File: rtl/object_layer_scheduler.sv
// Shares the VGA pixel among NUM_OBJ rectangles. Updates land in shadow
// registers and are committed to the live set in one cycle at the start of
// vertical blanking, so a visible frame always uses one consistent set.
// A 2-stage hit/priority pipeline drives the pixel and tracks overlaps.
module object_layer_scheduler #(
  parameter int                          NUM_OBJ  = 4,
  parameter int                          ID_W     = 2,
  parameter int                          V_ACTIVE = pong_pkg::V_ACTIVE,
  parameter logic [pong_pkg::RGB_W-1:0]  BG_COLOR = 3'b000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [pong_pkg::X_W-1:0]      CounterX,
  input  logic [pong_pkg::Y_W-1:0]      CounterY,
  input  logic                          inDisplayArea,
  object_layer_scheduler_if.slave       upd,
  output logic [pong_pkg::RGB_W-1:0]    pix_rgb,
  output logic [ID_W-1:0]               pix_id,
  output logic                          pix_hit,
  output logic [NUM_OBJ-1:0]            collide_mask,
  output logic                          frame_tick
);

  localparam logic [pong_pkg::Y_W:0] V_ACTIVE_L = (pong_pkg::Y_W + 1)'(V_ACTIVE);

  pong_pkg::sched_state_t state_reg, state_next;
  logic                   vblank;
  logic                   vblank_q_reg;
  logic                   commit;
  logic                   ready_state;
  logic                   upd_accept;
  pong_pkg::obj_t         upd_obj;

  logic [NUM_OBJ-1:0]           hit_vec;
  logic [NUM_OBJ-1:0]           hit_s1_reg;
  logic                         disp_s1_reg;
  logic [pong_pkg::RGB_W-1:0]   color_s1 [NUM_OBJ];
  logic                         overlap;
  logic [NUM_OBJ-1:0]           acc_reg;

  logic [pong_pkg::RGB_W-1:0]   pix_rgb_next;
  logic [ID_W-1:0]              pix_id_next;
  logic                         pix_hit_next;

  assign vblank     = ({1'b0, CounterY} >= V_ACTIVE_L);
  // Ready is a pure function of state; the reset term only forces it low
  // while reset is held.
  assign upd.upd_ready = ready_state & reset_n;
  assign upd_accept = upd.upd_valid & upd.upd_ready;
  assign frame_tick = commit;
  assign upd_obj    = pong_pkg::make_obj(upd.upd_en, upd.upd_x, upd.upd_y,
                                         upd.upd_w, upd.upd_h, upd.upd_color);

  // State register and blanking edge detector; vblank_q starts high so a
  // reset released inside blanking does not fire a spurious commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= pong_pkg::RUN;
      vblank_q_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      vblank_q_reg <= vblank;
    end
  end

  // Next-state and phase outputs: commit exactly once per blanking entry.
  always_comb begin
    state_next  = state_reg;
    commit      = 1'b0;
    ready_state = 1'b0;
    case (state_reg)
      pong_pkg::RUN: begin
        ready_state = 1'b1;
        if (vblank && !vblank_q_reg) begin
          state_next = pong_pkg::COMMIT;
        end
      end
      pong_pkg::COMMIT: begin
        commit     = 1'b1;
        state_next = pong_pkg::RUN;
      end
      default: state_next = pong_pkg::RUN;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : gen_slot
      pong_pkg::obj_t             shadow_reg;
      pong_pkg::obj_t             live_reg;
      logic [pong_pkg::RGB_W-1:0] color_reg;

      // Shadow copy: last accepted write for this slot wins.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shadow_reg <= '0;
        end else if (upd_accept && (upd.upd_id == ID_W'(gi))) begin
          shadow_reg <= upd_obj;
        end
      end

      // Live copy only changes in the commit cycle, never mid-picture.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          live_reg <= '0;
        end else if (commit) begin
          live_reg <= shadow_reg;
        end
      end

      // Stage 1 colour, aligned with the registered hit bit.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          color_reg <= '0;
        end else begin
          color_reg <= live_reg.color;
        end
      end

      assign color_s1[gi] = color_reg;

      obj_hit_test u_hit (
        .obj (live_reg),
        .cx  (CounterX),
        .cy  (CounterY),
        .hit (hit_vec[gi])
      );
    end
  endgenerate

  // Stage 1: capture the hit vector and display flag for this pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_s1_reg  <= '0;
      disp_s1_reg <= 1'b0;
    end else begin
      hit_s1_reg  <= hit_vec;
      disp_s1_reg <= inDisplayArea;
    end
  end

  // Stage 2 select: scanning downwards leaves the lowest hit slot as winner.
  always_comb begin
    pix_rgb_next = BG_COLOR;
    pix_id_next  = '0;
    pix_hit_next = |hit_s1_reg;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_s1_reg[i]) begin
        pix_rgb_next = color_s1[i];
        pix_id_next  = ID_W'(i);
      end
    end
    if (!disp_s1_reg) begin
      pix_rgb_next = '0;
      pix_id_next  = '0;
      pix_hit_next = 1'b0;
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_rgb <= '0;
      pix_id  <= '0;
      pix_hit <= 1'b0;
    end else begin
      pix_rgb <= pix_rgb_next;
      pix_id  <= pix_id_next;
      pix_hit <= pix_hit_next;
    end
  end

  assign overlap = disp_s1_reg && ($countones(hit_s1_reg) >= 2);

  // Overlap accumulator; a pixel in flight during commit seeds next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg      <= '0;
      collide_mask <= '0;
    end else if (commit) begin
      collide_mask <= acc_reg;
      acc_reg      <= overlap ? hit_s1_reg : '0;
    end else if (overlap) begin
      acc_reg <= acc_reg | hit_s1_reg;
    end
  end

endmodule

// File: tb/tb_object_layer_scheduler.sv
// Directed bench for object_layer_scheduler. Pixel probes push their
// expected result into a queue; a monitor tracks the 2-cycle pipeline and
// compares when the probed pixel reaches the outputs.
module tb_object_layer_scheduler;
  import pong_pkg::*;

  localparam logic [2:0] BG = 3'b111;

  logic       clk_tb = 1'b0;
  logic       reset_n;
  logic [9:0] cx;
  logic [8:0] cy;
  logic       disp;
  logic [2:0] pix_rgb;
  logic [1:0] pix_id;
  logic       pix_hit;
  logic [3:0] collide_mask;
  logic       frame_tick;

  object_layer_scheduler_if #(.ID_W(2)) upd_bus ();

  object_layer_scheduler #(
    .NUM_OBJ  (4),
    .ID_W     (2),
    .V_ACTIVE (480),
    .BG_COLOR (BG)
  ) dut (
    .clk           (clk_tb),
    .reset_n       (reset_n),
    .CounterX      (cx),
    .CounterY      (cy),
    .inDisplayArea (disp),
    .upd           (upd_bus),
    .pix_rgb       (pix_rgb),
    .pix_id        (pix_id),
    .pix_hit       (pix_hit),
    .collide_mask  (collide_mask),
    .frame_tick    (frame_tick)
  );

  always #5 clk_tb = ~clk_tb;

  typedef struct {
    logic [2:0] rgb;
    logic [1:0] id;
    logic       hit;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic probe = 1'b0, probe_d1 = 1'b0, probe_d2 = 1'b0;

  // Delay line matching the DUT pixel latency.
  always @(posedge clk_tb) begin
    probe_d1 <= probe;
    probe_d2 <= probe_d1;
  end

  // Monitor: compare a probed pixel once it reaches the outputs.
  always @(negedge clk_tb) begin
    if (probe_d2) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: rgb=%b id=%0d hit=%b, no expected entry", pix_rgb, pix_id, pix_hit);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (pix_rgb !== e.rgb || pix_id !== e.id || pix_hit !== e.hit) begin
          errors++;
          $display("FAIL pix_%s: got rgb=%b id=%0d hit=%b, want rgb=%b id=%0d hit=%b",
                   e.name, pix_rgb, pix_id, pix_hit, e.rgb, e.id, e.hit);
        end else begin
          $display("pix_%s: rgb=%b id=%0d hit=%b ok", e.name, pix_rgb, pix_id, pix_hit);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_tb);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end else begin
      $display("%s: %0h ok", name, act);
    end
  endtask

  task automatic probe_px(input string name, input int x, input int y, input bit d,
                          input logic [2:0] rgb, input logic [1:0] id, input logic hit);
    exp_t e;
    e.rgb = rgb; e.id = id; e.hit = hit; e.name = name;
    cx = 10'(x);
    cy = 9'(y);
    disp = d;
    probe = 1'b1;
    exp_q.push_back(e);
    cyc(1);
    probe = 1'b0;
    disp = 1'b0;
  endtask

  task automatic set_upd(input int id, input int x, input int y, input int w, input int h,
                         input logic [2:0] c, input logic en);
    upd_bus.upd_id    = 2'(id);
    upd_bus.upd_x     = 10'(x);
    upd_bus.upd_y     = 9'(y);
    upd_bus.upd_w     = 6'(w);
    upd_bus.upd_h     = 6'(h);
    upd_bus.upd_color = c;
    upd_bus.upd_en    = en;
  endtask

  task automatic wr(input int id, input int x, input int y, input int w, input int h,
                    input logic [2:0] c, input logic en);
    bit accepted = 1'b0;
    set_upd(id, x, y, w, h, c, en);
    upd_bus.upd_valid = 1'b1;
    for (int k = 0; k < 8 && !accepted; k++) begin
      if (upd_bus.upd_ready) accepted = 1'b1;
      cyc(1);
    end
    upd_bus.upd_valid = 1'b0;
    chk($sformatf("wr_accept_slot%0d", id), 32'(accepted), 32'd1);
  endtask

  task automatic do_commit();
    disp = 1'b0;
    cy = 9'd479;
    cyc(1);
    cy = 9'd480;
    cyc(1);
    chk("commit_tick", 32'(frame_tick), 32'd1);
    cyc(1);
    chk("commit_tick_end", 32'(frame_tick), 32'd0);
    cy = 9'd100;
  endtask

  initial begin
    reset_n = 1'b0;
    cx = '0;
    cy = 9'd490;
    disp = 1'b0;
    upd_bus.upd_valid = 1'b0;
    set_upd(0, 0, 0, 0, 0, 3'b000, 1'b0);

    // Reset state and release inside blanking.
    cyc(3);
    chk("rst_rgb", 32'(pix_rgb), 32'd0);
    chk("rst_id", 32'(pix_id), 32'd0);
    chk("rst_hit", 32'(pix_hit), 32'd0);
    chk("rst_ready", 32'(upd_bus.upd_ready), 32'd0);
    chk("rst_mask", 32'(collide_mask), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("blank_no_tick", 32'(frame_tick), 32'd0);
    end
    chk("ready_after_rst", 32'(upd_bus.upd_ready), 32'd1);

    // Commit: update invisible until the next frame.
    cy = 9'd200;
    wr(0, 100, 50, 8, 8, 3'b100, 1'b1);
    probe_px("pre_commit", 100, 50, 1'b1, BG, 2'd0, 1'b0);
    do_commit();
    probe_px("s0_hit", 100, 50, 1'b1, 3'b100, 2'd0, 1'b1);
    probe_px("s0_corner", 107, 57, 1'b1, 3'b100, 2'd0, 1'b1);
    probe_px("s0_right", 108, 50, 1'b1, BG, 2'd0, 1'b0);
    probe_px("s0_below", 100, 58, 1'b1, BG, 2'd0, 1'b0);
    probe_px("s0_nodisp", 100, 50, 1'b0, 3'b000, 2'd0, 1'b0);

    // Priority and collision tracking.
    wr(0, 100, 50, 8, 8, 3'b100, 1'b0);
    wr(1, 100, 50, 4, 4, 3'b010, 1'b1);
    wr(3, 100, 50, 4, 4, 3'b001, 1'b1);
    do_commit();
    chk("mask_none", 32'(collide_mask), 32'h0);
    probe_px("prio", 101, 51, 1'b1, 3'b010, 2'd1, 1'b1);
    do_commit();
    chk("mask_1010", 32'(collide_mask), 32'hA);
    probe_px("prio_again", 101, 51, 1'b1, 3'b010, 2'd1, 1'b1);
    wr(3, 300, 50, 4, 4, 3'b001, 1'b1);
    do_commit();
    chk("mask_still_1010", 32'(collide_mask), 32'hA);
    probe_px("s1_alone", 101, 51, 1'b1, 3'b010, 2'd1, 1'b1);
    probe_px("s3_moved", 300, 50, 1'b1, 3'b001, 2'd3, 1'b1);
    probe_px("s1_edge", 103, 53, 1'b1, 3'b010, 2'd1, 1'b1);
    do_commit();
    chk("mask_cleared", 32'(collide_mask), 32'h0);

    // Handshake held through COMMIT stalls one cycle.
    cy = 9'd479;
    cyc(1);
    cy = 9'd480;
    cyc(1);
    chk("hs_tick", 32'(frame_tick), 32'd1);
    chk("hs_ready_commit", 32'(upd_bus.upd_ready), 32'd0);
    set_upd(2, 200, 60, 4, 4, 3'b100, 1'b1);
    upd_bus.upd_valid = 1'b1;
    cyc(1);
    chk("hs_ready_after", 32'(upd_bus.upd_ready), 32'd1);
    cyc(1);
    upd_bus.upd_valid = 1'b0;
    cy = 9'd100;
    probe_px("s2_pending", 201, 61, 1'b1, BG, 2'd0, 1'b0);
    do_commit();
    probe_px("s2_held", 201, 61, 1'b1, 3'b100, 2'd2, 1'b1);
    wr(2, 200, 60, 4, 4, 3'b001, 1'b1);
    wr(2, 200, 60, 4, 4, 3'b010, 1'b1);
    do_commit();
    probe_px("s2_last", 201, 61, 1'b1, 3'b010, 2'd2, 1'b1);

    // Edge cases: zero width and right-edge no wrap.
    wr(0, 400, 100, 0, 8, 3'b100, 1'b1);
    wr(1, 1020, 100, 8, 8, 3'b010, 1'b1);
    do_commit();
    probe_px("w0", 400, 100, 1'b1, BG, 2'd0, 1'b0);
    probe_px("nowrap", 3, 100, 1'b1, BG, 2'd0, 1'b0);
    probe_px("x1020", 1020, 100, 1'b1, 3'b010, 2'd1, 1'b1);
    probe_px("x1023", 1023, 107, 1'b1, 3'b010, 2'd1, 1'b1);

    // Asynchronous reset mid-line.
    cx = 10'd1021;
    cy = 9'd100;
    disp = 1'b1;
    cyc(3);
    chk("pre_rst_hit", 32'(pix_hit), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_hit", 32'(pix_hit), 32'd0);
    chk("midrst_rgb", 32'(pix_rgb), 32'd0);
    chk("midrst_ready", 32'(upd_bus.upd_ready), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    disp = 1'b0;
    cyc(1);
    do_commit();
    probe_px("post_rst_s1", 1021, 100, 1'b1, BG, 2'd0, 1'b0);
    probe_px("post_rst_s2", 201, 61, 1'b1, BG, 2'd0, 1'b0);
    cyc(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
